// File: rtl/ifid_stall_ctrl_pkg.sv
// Shared front-end pipeline definitions: NOP encoding, default control width,
// stall FSM state encoding and the IF/ID register payload.
package ifid_stall_ctrl_pkg;

    localparam logic [31:0]  NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned  CTRL_W_DEF = 9;

    localparam logic [0:0]   ST_RUN   = 1'b0;
    localparam logic [0:0]   ST_STALL = 1'b1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/ifid_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ifid_stall_ctrl.sv
// IF/ID register and ID/EX control stage with stall/flush handling, a stall
// episode FSM, a runaway-stall watchdog and saturating event counters.
module ifid_stall_ctrl
    import ifid_stall_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W    = CTRL_W_DEF,
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall_Data_Hazard,
    input  logic              flush,
    input  logic [31:0]       instr_if,
    input  logic [31:0]       pc_plus4_if,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              clr_stats,
    output logic              PCWrite,
    output logic [31:0]       instr_id,
    output logic [31:0]       pc_plus4_id,
    output logic              valid_id,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              valid_ex,
    output logic              stall_active,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

    logic             stall_eff;
    ifid_t            ifid_q;
    logic [0:0]       state_q, state_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             timeout_d;
    logic             at_limit;

    // Flush wins over a coincident stall request.
    assign stall_eff = Stall_Data_Hazard & ~flush;
    assign PCWrite   = ~stall_eff;
    assign at_limit  = (run_len_q == RUN_W'(MAX_STALL));

    assign instr_id     = ifid_q.instr;
    assign pc_plus4_id  = ifid_q.pc_plus4;
    assign valid_id     = ifid_q.valid;
    assign stall_active = (state_q == ST_STALL);

    // IF/ID register: squash keeps the PC+4 so debug still sees where we were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
        end else if (flush) begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else if (!stall_eff) begin
            ifid_q <= '{instr: instr_if, pc_plus4: pc_plus4_if, valid: 1'b1};
        end
    end

    // ID/EX control: stall or flush inject a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ex  <= '0;
            valid_ex <= 1'b0;
        end else if (flush || stall_eff) begin
            ctrl_ex  <= '0;
            valid_ex <= 1'b0;
        end else begin
            ctrl_ex  <= ctrl_id;
            valid_ex <= ifid_q.valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            run_len_q     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_len_q     <= run_len_d;
            stall_timeout <= timeout_d;
        end
    end

    // Stall episode tracking and sticky watchdog.
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        timeout_d = stall_timeout;

        if (state_q == ST_STALL) begin
            if (stall_eff) begin
                if (!at_limit) run_len_d = run_len_q + RUN_W'(1);
            end else begin
                state_d   = ST_RUN;
                run_len_d = '0;
            end
        end else begin
            if (stall_eff) begin
                state_d   = ST_STALL;
                run_len_d = RUN_W'(1);
            end
        end

        if (clr_stats) begin
            timeout_d = 1'b0;
        end else if (stall_eff && at_limit) begin
            timeout_d = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_eff),
        .clr   (clr_stats),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .clr   (clr_stats),
        .cnt   (flush_cnt)
    );

endmodule

// File: doc/ifid_stall_ctrl.md
Name: ifid_stall_ctrl

Overview:
Consumer end of the data-hazard stall signal. Owns the IF/ID pipeline register and the control half of ID/EX, and applies stall/flush to the front end: holds PC and IF/ID, injects bubbles into EX, and squashes on branch flush. Tracks stall episodes with a small FSM, a runaway-stall watchdog and saturating stall/flush counters. Sits between fetch, decode/control and the hazard detection unit in the 5-stage MIPS pipeline.

Parameters:
CTRL_W, 9, width of the decoded control bundle passed ID -> EX
MAX_STALL, 4, consecutive stall cycles tolerated before the watchdog trips
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
Stall_Data_Hazard  in  1  stall request from the hazard detection unit (combinational, same cycle)
flush  in  1  branch/jump taken; squash the younger instruction
instr_if  in  32  fetched instruction
pc_plus4_if  in  32  PC+4 of the fetched instruction
ctrl_id  in  CTRL_W  control bundle decoded from instr_id
clr_stats  in  1  synchronous clear of counters and watchdog flag
PCWrite  out  1  PC update enable (combinational)
instr_id  out  32  IF/ID instruction
pc_plus4_id  out  32  IF/ID PC+4
valid_id  out  1  IF/ID holds a real instruction
ctrl_ex  out  CTRL_W  ID/EX control bundle (zero = bubble)
valid_ex  out  1  ID/EX holds a real instruction
stall_active  out  1  FSM is in STALL
stall_timeout  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  cycles spent stalled, saturating
flush_cnt  out  CNT_W  flush events, saturating

Behaviour:
- Reset (async, rst_n=0): instr_id=0 (NOP), pc_plus4_id=0, valid_id=0, ctrl_ex=0, valid_ex=0, FSM=RUN, run length=0, stall_timeout=0, stall_cnt=0, flush_cnt=0. Reset mid-stall abandons the stall with no residue.
- Effective stall: stall_eff = Stall_Data_Hazard & ~flush. Flush has priority over stall on coincidence.
- PCWrite = ~stall_eff. This is combinational, so the PC holds in the same cycle as the request.
- IF/ID on each rising edge:
  - flush: instr_id=0, valid_id=0, pc_plus4_id held.
  - else stall_eff: all IF/ID fields held.
  - else: load instr_if and pc_plus4_if, valid_id=1.
- ID/EX control on each rising edge:
  - flush or stall_eff: ctrl_ex=0, valid_ex=0 (bubble).
  - else: ctrl_ex=ctrl_id, valid_ex=valid_id.
- Latency: one cycle IF -> ID and one cycle ID -> EX. Each Stall_Data_Hazard cycle inserts exactly one bubble.
- FSM states: RUN, STALL, and run length run_len (0..MAX_STALL).
  - RUN -> STALL on stall_eff; run_len=1.
  - STALL stays while stall_eff; run_len increments and saturates at MAX_STALL.
  - STALL -> RUN on ~stall_eff, including on flush; run_len=0.
  - stall_active=1 only while in STALL.
- Watchdog: when stall_eff is high with run_len==MAX_STALL, stall_timeout sets to 1 on the next edge. It is sticky and is cleared only by clr_stats or reset. It does not override stalling.
- Counters:
  - stall_cnt += 1 on every edge with stall_eff=1.
  - flush_cnt += 1 on every edge with flush=1.
  - Both saturate at all-ones and do not wrap.
- clr_stats: on the next edge, counters=0 and stall_timeout=0. It has priority over increments in the same cycle. Pipeline registers and FSM are unaffected.

Decomposition:
- Shared pipeline package holds:
  - NOP encoding (32'h0000_0000)
  - CTRL_W default
  - FSM state encoding (RUN=1'b0, STALL=1'b1)
- One natural sub-module, sat_counter (parameter width, inputs inc and clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with Stall_Data_Hazard=1 -> all outputs zero immediately; PCWrite=0 while the stall input stays high.
- Plain flow: instr_if=0x8C080004 then 0x01094020, no stall -> instr_id follows one cycle later, ctrl_ex follows ctrl_id one cycle later, valid_ex=1.
- Load-use single stall: Stall_Data_Hazard=1 for 1 cycle with instr_id=0x01094020 -> PCWrite=0 that cycle, instr_id held, ctrl_ex=0 and valid_ex=0 next cycle, stall_cnt=1, stall_active pulses for 1 cycle.
- Flush vs stall: flush=1 and Stall_Data_Hazard=1 together -> PCWrite=1, instr_id=0, valid_id=0, ctrl_ex=0, flush_cnt=1, stall_cnt unchanged, FSM=RUN.
- Watchdog: stall held for MAX_STALL+1=5 cycles -> stall_timeout=1 after the 5th edge and stays 1 after release; clr_stats=1 -> stall_timeout=0, stall_cnt=0.
- Saturation: with CNT_W=4, 20 flush cycles -> flush_cnt=15 and holds; clr_stats plus flush in the same cycle -> flush_cnt=0.
